// File: rtl/rr_mux21_stage_pkg.sv
// Shared constants for the round-robin mux21 stage: select encoding and FSM states.
package rr_mux21_stage_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_mux21_stage_if.sv
// Handshake bundle: two producer channels in, one registered consumer channel out.
interface rr_mux21_stage_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             out_sel;

    // Environment side: producers and consumer.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_sel
    );

    // Arbitration stage side.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_mux21_stage_mux21.sv
// One-bit 2:1 mux; sel=0 passes in0, sel=1 passes in1.
module mux21 (
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic y
);
    assign y = sel ? in1 : in0;
endmodule

// File: rtl/rr_mux21_stage.sv
// Round-robin 2-input arbiter feeding a bank of mux21 cells into a one-entry
// output register with valid/ready toward the consumer.
module rr_mux21_stage
    import rr_mux21_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux21_stage_if.slave     bus
);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             grant_valid;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_p0;
    logic             sel_p0;

    // Under contention the channel not served last wins; idle cycles keep the pointer.
    always_comb begin
        grant       = SEL_A;
        grant_valid = bus.a_valid | bus.b_valid;
        if (bus.a_valid && bus.b_valid) begin
            grant = ~last_grant;
        end else if (bus.b_valid) begin
            grant = SEL_B;
        end
    end

    assign can_accept  = (state == ST_EMPTY) | bus.out_ready;
    assign xfer        = can_accept & grant_valid;
    assign bus.a_ready = xfer & (grant == SEL_A);
    assign bus.b_ready = xfer & (grant == SEL_B);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux21 u_mux (
            .in0 (bus.a_data[i]),
            .in1 (bus.b_data[i]),
            .sel (grant),
            .y   (mux_out[i])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (xfer) state_next = ST_FULL;
            ST_FULL:  if (bus.out_ready && !xfer) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    // Stage p0: output register, loaded on every accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            last_grant <= SEL_B;
            data_p0    <= '0;
            sel_p0     <= SEL_A;
        end else begin
            state <= state_next;
            if (xfer) begin
                last_grant <= grant;
                data_p0    <= mux_out;
                sel_p0     <= grant;
            end
        end
    end

    assign bus.out_valid = (state == ST_FULL);
    assign bus.out_data  = data_p0;
    assign bus.out_sel   = sel_p0;

endmodule

// File: tb/tb_rr_mux21_stage.sv
// Directed bench for rr_mux21_stage: reset, single source, fairness, backpressure, drain, pointer hold.
module tb_rr_mux21_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_mux21_stage_if #(.WIDTH(8)) bus ();

    rr_mux21_stage #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid   = 1'b0;
        bus.b_valid   = 1'b0;
        bus.a_data    = 8'h00;
        bus.b_data    = 8'h00;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_init: valid=%b data=%h sel=%b, want 0 00 0", bus.out_valid, bus.out_data, bus.out_sel);
        end
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b, want 0 0", bus.a_ready, bus.b_ready);
        end
        tick();
        rst = 1'b0;
        // Load 5A from A so last_grant points at A, then reset between edges.
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h5A;
        tick();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
            failures++;
            $display("FAIL reset_load: valid=%b data=%h, want 1 5a", bus.out_valid, bus.out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: valid=%b data=%h sel=%b, want 0 00 0", bus.out_valid, bus.out_data, bus.out_sel);
        end
        tick();
        rst = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 8'hE1;
        bus.b_data  = 8'hE2;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_pointer: a_ready=%b b_ready=%b, want 1 0", bus.a_ready, bus.b_ready);
        end
        idle_inputs();
    endtask

    task automatic test_single_source();
        do_reset();
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h3C;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: a_ready=%b b_ready=%b, want 1 0", bus.a_ready, bus.b_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_sel !== 1'b0) begin
            failures++;
            $display("FAIL single_out: valid=%b data=%h sel=%b, want 1 3c 0", bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_data [6];
        logic       exp_sel  [6];
        logic [7:0] a_word;
        logic [7:0] b_word;
        exp_data = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        exp_sel  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        a_word = 8'hA0;
        b_word = 8'hB0;
        do_reset();
        bus.a_valid   = 1'b1;
        bus.b_valid   = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.a_data = a_word;
            bus.b_data = b_word;
            #1;
            checks++;
            if (bus.a_ready !== ~exp_sel[i] || bus.b_ready !== exp_sel[i]) begin
                failures++;
                $display("FAIL contention_ready[%0d]: a_ready=%b b_ready=%b, want %b %b", i, bus.a_ready, bus.b_ready, ~exp_sel[i], exp_sel[i]);
            end
            if (bus.a_ready === 1'b1) a_word = a_word + 8'h01;
            if (bus.b_ready === 1'b1) b_word = b_word + 8'h01;
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data[i] || bus.out_sel !== exp_sel[i]) begin
                failures++;
                $display("FAIL contention_out[%0d]: valid=%b data=%h sel=%b, want 1 %h %b", i, bus.out_valid, bus.out_data, bus.out_sel, exp_data[i], exp_sel[i]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h11;
        bus.out_ready = 1'b1;
        tick();
        bus.b_valid   = 1'b1;
        bus.b_data    = 8'h33;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.a_data = 8'h20 + 8'(i);
            #1;
            checks++;
            if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready[%0d]: a_ready=%b b_ready=%b, want 0 0", i, bus.a_ready, bus.b_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_sel !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h sel=%b, want 1 11 0", i, bus.out_valid, bus.out_data, bus.out_sel);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: a_ready=%b b_ready=%b, want 0 1", bus.a_ready, bus.b_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.out_sel !== 1'b1) begin
            failures++;
            $display("FAIL bp_replace: valid=%b data=%h sel=%b, want 1 33 1", bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    task automatic test_drain();
        do_reset();
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h44;
        bus.out_ready = 1'b1;
        tick();
        bus.a_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: valid=%b, want 0", bus.out_valid);
        end
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 8'h55;
        bus.b_data  = 8'h66;
        tick();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h66 || bus.out_sel !== 1'b1) begin
            failures++;
            $display("FAIL drain_next_grant: valid=%b data=%h sel=%b, want 1 66 1", bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    task automatic test_pointer_hold();
        do_reset();
        bus.b_valid   = 1'b1;
        bus.b_data    = 8'h77;
        bus.out_ready = 1'b1;
        tick();
        bus.b_valid = 1'b0;
        checks++;
        if (bus.out_data !== 8'h77 || bus.out_sel !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: data=%h sel=%b, want 77 1", bus.out_data, bus.out_sel);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: valid=%b, want 0", bus.out_valid);
        end
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.a_data  = 8'h88;
        bus.b_data  = 8'h99;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_grant: a_ready=%b b_ready=%b, want 1 0", bus.a_ready, bus.b_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h88 || bus.out_sel !== 1'b0) begin
            failures++;
            $display("FAIL hold_out: valid=%b data=%h sel=%b, want 1 88 0", bus.out_valid, bus.out_data, bus.out_sel);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_drain();
        test_pointer_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
